dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Parametrised RV32 data memory with load/store alignment, sub-word stores via byte enables,
//  and sign/zero-extended loads. Successor of the fixed 4-value RAM demo top.
//  Sits between core EX/MEM stage and the word array; a second read-only debug port feeds the 7-seg LED driver.
//  After reset, an internal clear FSM zero-fills the array before accepting requests.
// PARAMETERS
//  DEPTH_LOG2      6             word-address bits; DEPTH = 2**DEPTH_LOG2 words of 32 bits
//  CLEAR_ON_RESET  1             1: run CLEAR state after reset; 0: go straight to IDLE
//  INIT_VALUE      32'h0000_0000 word written to every location during CLEAR
// PORTS
//  clk        in   1             single clock, all logic on posedge
//  rst        in   1             synchronous, active-high reset
//  req_valid  in   1             request present
//  req_we     in   1             1 = store, 0 = load
//  req_funct3 in   3             RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   DEPTH_LOG2+2  byte address
//  req_wdata  in   32            store data, LSB-aligned
//  req_ready  out  1             request accepted when req_valid && req_ready
//  rsp_valid  out  1             one-cycle pulse, response to request accepted previous cycle
//  rsp_rdata  out  32            extended load data; 0 for stores and errors
//  rsp_err    out  1             misaligned or illegal funct3; qualified by rsp_valid
//  dbg_addr   in   DEPTH_LOG2    debug word address (LED display)
//  dbg_rdata  out  32            registered debug read data
// BEHAVIOUR
//  Reset (rst=1 at posedge): state<=CLEAR (or IDLE if CLEAR_ON_RESET=0), clr_cnt<=0,
//   rsp_valid<=0, rsp_rdata<=0, rsp_err<=0, dbg_rdata<=0. Array contents are not reset by rst itself.
//  FSM: CLEAR -> writes INIT_VALUE to word clr_cnt each cycle, clr_cnt++; req_ready=0;
//   at clr_cnt==DEPTH-1 -> IDLE (exactly DEPTH cycles in CLEAR). IDLE: req_ready=1; no exit but rst.
//  rst during CLEAR restarts the clear from word 0. rst with a response pending drops it (rsp_valid=0);
//   stores committed before the reset edge remain in the array.
//  Throughput: one request per cycle; latency 1 (rsp_valid on the edge after acceptance).
//  Word index = req_addr[DEPTH_LOG2+1:2]; lane = req_addr[1:0].
//  Legal: load funct3 in {000,001,010,100,101}; store funct3 in {000,001,010}. Other codes -> error.
//  Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0 -> error.
//  Error: no array write, rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  Store: SB be=4'b0001<<lane, data {4{wdata[7:0]}}; SH be=lane[1]?1100:0011, data {2{wdata[15:0]}};
//   SW be=1111. Write at the accept edge; rsp_rdata=0, rsp_err=0.
//  Load: word read registered at the accept edge; extract byte/half by lane;
//   B/H sign-extend, BU/HU zero-extend, W pass-through.
//  Store followed next cycle by load to the same word returns the new data (no hazard).
//  Debug port: dbg_rdata <= mem[dbg_addr] every cycle. A write in the same cycle to the same word
//   yields the OLD value (read-before-write); the new value appears one cycle later. Also active during CLEAR.
//  req_* ignored when req_ready=0; the requester holds them until acceptance.
// STRUCTURE
//  dmem_defs.vh (shared): funct3 codes (F3_B/H/W/BU/HU), FSM state codes (ST_CLEAR, ST_IDLE).
//  Sub-module dmem_lane_align (combinational): store be/data replication, load extract+extend,
//   misalign/illegal detect. Array, FSM, clear counter and response registers stay in dmem_lsu.
// TESTING
//  1 rst 1 cycle, CLEAR_ON_RESET=1, DEPTH_LOG2=6 -> req_ready=0 for 64 cycles, then 1; dbg reads of words 0..63 = 0.
//  2 SW 0x8000_00F0 @0x10; LB @0x10 -> 0xFFFF_FFF0; LBU @0x10 -> 0x0000_00F0; LH @0x12 -> 0xFFFF_8000.
//  3 SW 0x1122_3344 @0x20; SB 0xAB @0x21; SH 0xBEEF @0x22; LW @0x20 -> 0xBEEF_AB44, all rsp_err=0.
//  4 LW @0x06, SH @0x03, funct3=011 load, SBU(100) store -> each rsp_valid=1, rsp_err=1, rsp_rdata=0; word unchanged.
//  5 back-to-back SW 0x5 @0x04 then LW @0x04 in consecutive cycles -> rsp 0x5; dbg_addr=1 same cycle as SW -> old, then 0x5.
//  6 rst mid-CLEAR at cnt=30 -> full 64-cycle clear restarts; rst one cycle after an accepted LW -> no rsp_valid.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I width codes and FSM states.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Combinational lane handling: store byte-enables/replication, load extract+extend, error detect.
module dmem_lsu_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic        illegal;
  logic        misalign;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_o     = '0;
    wdata_o  = '0;
    rdata_o  = '0;
    illegal  = 1'b1;
    misalign = 1'b0;
    byte_v   = rword_i[{lane_i, 3'b000} +: 8];
    half_v   = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (funct3_i)
      F3_B: begin
        illegal = 1'b0;
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_v[7]}}, byte_v};
      end
      F3_H: begin
        illegal  = 1'b0;
        misalign = lane_i[0];
        be_o     = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{wdata_i[15:0]}};
        rdata_o  = {{16{half_v[15]}}, half_v};
      end
      F3_W: begin
        illegal  = 1'b0;
        misalign = |lane_i;
        be_o     = 4'b1111;
        wdata_o  = wdata_i;
        rdata_o  = rword_i;
      end
      // Unsigned widths exist only for loads.
      F3_BU: begin
        illegal = we_i;
        rdata_o = {24'b0, byte_v};
      end
      F3_HU: begin
        illegal  = we_i;
        misalign = lane_i[0];
        rdata_o  = {16'b0, half_v};
      end
      default: ;
    endcase
    err_o = illegal | misalign;
    if (illegal | misalign) begin
      be_o    = '0;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory with aligned sub-word access, post-reset clear FSM and a registered debug read port.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 6,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] INIT_VALUE     = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DEPTH_LOG2+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [31:0]           dbg_rdata,
  output state_e                dbg_state
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = DEPTH_LOG2'(DEPTH - 1);

  logic [31:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we;

  logic                  rsp_valid_q, rsp_err_q;
  logic [31:0]           rsp_rdata_q, dbg_rdata_q;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic                  accept;
  logic                  st_we;
  logic [3:0]            st_be;
  logic [31:0]           st_data;
  logic [31:0]           ld_data;
  logic                  acc_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_IDLE:  req_ready = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake: a request transfers on a posedge where req_valid && req_ready; the requester
  // holds req_* stable until then. rsp_valid pulses for one cycle right after that edge; reset wins.
  assign accept   = req_valid && req_ready && !rst;
  assign word_idx = req_addr[DEPTH_LOG2+1:2];
  assign lane     = req_addr[1:0];
  assign st_we    = accept && req_we && !acc_err;

  dmem_lsu_lane_align u_align (
    .we_i     (req_we),
    .funct3_i (req_funct3),
    .lane_i   (lane),
    .wdata_i  (req_wdata),
    .rword_i  (mem_q[word_idx]),
    .be_o     (st_be),
    .wdata_o  (st_data),
    .rdata_o  (ld_data),
    .err_o    (acc_err)
  );

  // Array contents deliberately survive rst; only the clear FSM initialises them.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem_q[clr_cnt_q] <= INIT_VALUE;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && acc_err;
      rsp_rdata_q <= (accept && !req_we && !acc_err) ? ld_data : '0;
      dbg_rdata_q <= mem_q[dbg_addr];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus random traffic against a byte-addressed reference memory.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam int DL    = 6;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  dbg_addr = 6'h0;
  logic [31:0] dbg_rdata;
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_b [256];
  logic [32:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_LOG2(DL), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [7:0] addr);
    int  sz;
    logic legal;
    sz    = 1 << f3[1:0];
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((int'(addr) % sz) != 0);
  endfunction

  task automatic ref_zero();
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                             input logic [31:0] wd);
    int          sz;
    int          a;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    a  = int'(addr);
    v  = 32'h0;
    if (ref_err(we, f3, addr)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (we) begin
      for (int i = 0; i < sz; i++) ref_b[a+i] = wd[8*i +: 8];
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_b[a+i];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      exp_q.push_back({1'b0, v});
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (rsp_valid) begin
      chk("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_err", {31'b0, rsp_err}, {31'b0, e[32]});
        chk("sb_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                      input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_apply(we, f3, addr, wd);
    #1 req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] data, input logic err);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_rdata, data);
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, err});
  endtask

  // Called at a negedge with rst just released; counts cycles until req_ready rises.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (!req_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, DEPTH);
    ref_zero();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic dbg_check(input string tag, input int w, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = 6'(w);
    @(negedge clk);
    chk(tag, dbg_rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] f3;
    logic [7:0] addr;
    logic       we;
    ref_zero();
    repeat (2) @(posedge clk);

    // 1: reset values, clear length, cleared contents
    pulse_rst();
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_ready_low", {31'b0, req_ready}, 32'd0);
    wait_clear("clear_cycles");
    for (int w = 0; w < DEPTH; w++) dbg_check("clear_word", w, 32'h0);

    // 2: sign/zero extension
    send(1'b1, F3_W, 8'h10, 32'h8000_00F0); expect_rsp("sw10", 32'h0, 1'b0);
    send(1'b0, F3_B, 8'h10, 32'h0);         expect_rsp("lb10", 32'hFFFF_FFF0, 1'b0);
    send(1'b0, F3_BU, 8'h10, 32'h0);        expect_rsp("lbu10", 32'h0000_00F0, 1'b0);
    send(1'b0, F3_H, 8'h12, 32'h0);         expect_rsp("lh12", 32'hFFFF_8000, 1'b0);

    // 3: sub-word merging
    send(1'b1, F3_W, 8'h20, 32'h1122_3344); expect_rsp("sw20", 32'h0, 1'b0);
    send(1'b1, F3_B, 8'h21, 32'h0000_00AB); expect_rsp("sb21", 32'h0, 1'b0);
    send(1'b1, F3_H, 8'h22, 32'h0000_BEEF); expect_rsp("sh22", 32'h0, 1'b0);
    send(1'b0, F3_W, 8'h20, 32'h0);         expect_rsp("lw20", 32'hBEEF_AB44, 1'b0);

    // 4: errors leave the array untouched
    send(1'b0, F3_W, 8'h06, 32'h0);         expect_rsp("lw_mis", 32'h0, 1'b1);
    send(1'b1, F3_H, 8'h03, 32'hFFFF_FFFF); expect_rsp("sh_mis", 32'h0, 1'b1);
    send(1'b0, 3'b011, 8'h20, 32'h0);       expect_rsp("ld_ill", 32'h0, 1'b1);
    send(1'b1, F3_BU, 8'h20, 32'hFFFF_FFFF); expect_rsp("st_ill", 32'h0, 1'b1);
    send(1'b0, F3_W, 8'h20, 32'h0);         expect_rsp("lw20_keep", 32'hBEEF_AB44, 1'b0);

    // 5: store-then-load back to back, debug read-before-write
    send(1'b1, F3_W, 8'h04, 32'h5);
    send(1'b0, F3_W, 8'h04, 32'h0);
    expect_rsp("b2b_lw", 32'h5, 1'b0);
    @(negedge clk);
    dbg_addr = 6'd1;
    send(1'b1, F3_W, 8'h04, 32'h7);
    @(negedge clk);
    chk("dbg_old", dbg_rdata, 32'h5);
    @(negedge clk);
    chk("dbg_new", dbg_rdata, 32'h7);

    // 6a: reset on the acceptance edge of a load drops the response
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 8'h20;
    rst        = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_drop_valid", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b0;
    wait_clear("clear_after_drop");
    dbg_check("cleared_w8", 8, 32'h0);

    // 6b: reset mid-clear restarts the full clear
    send(1'b1, F3_W, 8'h40, 32'hDEAD_BEEF);
    pulse_rst();
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clear_restart");
    dbg_check("cleared_w16", 16, 32'h0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) addr = addr & ~8'((1 << f3[1:0]) - 1);
      send(we, f3, addr, $urandom);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    for (int w = 0; w < DEPTH; w++) dbg_check("final_word", w, ref_word(w));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=0x%08h expected=0x%08h", total, 0);
    $fatal(1, "timeout");
  end

endmodule
